// File: rtl/rgb_pattern_sequencer.sv
// Programmable N-step RGB colour sequencer with per-channel PWM, manual/auto stepping and an error state.
// Optional feature: define RGB_SEQ_REVERSE_EN to honour step_dir (reverse stepping).
module rgb_pattern_sequencer #(
  parameter int NUM_STEPS   = 4,
  parameter int PWM_BITS    = 4,
  parameter int DWELL_TICKS = 1000,
  localparam int IDX_W      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_req,
  input  logic                  step_dir,
  input  logic                  mode_auto,
  input  logic [IDX_W-1:0]      seq_last,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [3*PWM_BITS-1:0] cfg_data,
  output logic [2:0]            rgb,
  output logic [IDX_W-1:0]      step_idx,
  output logic                  wrap,
  output logic                  error
);

  localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_STEPS - 1);
  localparam logic [DW_W-1:0]     DWELL_MAX = DW_W'(DWELL_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  typedef enum logic [1:0] {S_MANUAL, S_AUTO, S_ERROR} state_t;

  state_t                  r_state, w_state_nx;
  logic [IDX_W-1:0]        r_idx, w_idx_nx;
  logic                    r_wrap, w_wrap_nx;
  logic [DW_W-1:0]         r_dwell;
  logic [PWM_BITS-1:0]     r_pwm_cnt;
  logic [2:0]              r_rgb;
  logic [3*PWM_BITS-1:0]   r_table [NUM_STEPS];
  logic [3*PWM_BITS-1:0]   w_duty;
  logic                    w_invalid, w_advance;

  function automatic logic [3*PWM_BITS-1:0] default_entry(input int k);
    return {{(2*PWM_BITS){1'b0}}, DUTY_FULL} << (PWM_BITS * (k % 3));
  endfunction

`ifndef RGB_SEQ_REVERSE_EN
  logic w_unused_dir;
  assign w_unused_dir = step_dir;
`endif

  assign w_invalid = (seq_last > LAST_IDX);
  assign w_duty    = r_table[r_idx];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_advance  = 1'b0;
    w_idx_nx   = r_idx;
    w_wrap_nx  = 1'b0;
    error      = 1'b0;

    if (w_invalid)               w_state_nx = S_ERROR;
    else if (r_state == S_ERROR) w_state_nx = S_MANUAL;
    else                         w_state_nx = mode_auto ? S_AUTO : S_MANUAL;

    case (r_state)
      S_MANUAL: w_advance = step_req;
      S_AUTO:   w_advance = step_req || (r_dwell == DWELL_MAX);
      default:  error     = 1'b1;
    endcase
    if (w_invalid) w_advance = 1'b0;

    if (r_state == S_ERROR) begin
      w_idx_nx = '0;
    end else if (w_advance) begin
`ifdef RGB_SEQ_REVERSE_EN
      if (step_dir) begin
        if (r_idx == '0 || r_idx > seq_last) begin
          w_idx_nx  = seq_last;
          w_wrap_nx = 1'b1;
        end else begin
          w_idx_nx = r_idx - 1'b1;
        end
      end else
`endif
      if (r_idx >= seq_last) begin
        w_idx_nx  = '0;
        w_wrap_nx = 1'b1;
      end else begin
        w_idx_nx = r_idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_MANUAL;
      r_idx     <= '0;
      r_wrap    <= 1'b0;
      r_dwell   <= '0;
      r_pwm_cnt <= '0;
      r_rgb     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_wrap    <= w_wrap_nx;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      // Dwell restarts on any advance, mode change, or outside auto mode.
      if (r_state != S_AUTO || w_state_nx != r_state || w_advance) r_dwell <= '0;
      else                                                         r_dwell <= r_dwell + 1'b1;
      for (int ch = 0; ch < 3; ch++) begin
        r_rgb[ch] <= (w_state_nx != S_ERROR) &&
                     (w_duty[ch*PWM_BITS +: PWM_BITS] > r_pwm_cnt);
      end
    end
  end

  // NOTE: the colour table is reset explicitly because its power-up pattern is visible behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STEPS; k++) r_table[k] <= default_entry(k);
    end else if (cfg_we && cfg_addr <= LAST_IDX) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  assign rgb      = r_rgb;
  assign step_idx = r_idx;
  assign wrap     = r_wrap;

endmodule
